// File: rtl/seq_addsub_if.sv
// seq_addsub_if: operand-issue and result handshake bundle for seq_addsub.
// master = operand issuer / result consumer, slave = the adder/subtractor.
interface seq_addsub_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock, LSB first, with a registered carry between slices.
// Optional feature macro: SEQ_ADDSUB_SAT_EN saturates the result to the signed limit on overflow.
module seq_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic         clk,
    input logic         rst_n,
    seq_addsub_if.slave bus
);
    localparam int unsigned N    = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    // Reject illegal parametrisations at elaboration time.
    if (DIGIT < 1) begin : g_bad_digit
        $error("seq_addsub: DIGIT must be >= 1");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_ratio
        $error("seq_addsub: WIDTH must be a multiple of DIGIT");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("seq_addsub: WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic              last_slice;
    logic [DIGIT:0]    slice_sum;
    logic              carry_into_msb;
    logic              ovf_calc;
    logic [WIDTH-1:0]  acc_shift;
    logic [WIDTH-1:0]  final_res;

    assign last_slice = (cnt_q == CntW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRun;
            StRun:   if (last_slice) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decode straight from state.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
    end

    // Slice adder; the MSB's incoming carry is recovered from the sum bit of the last digit.
    always_comb begin
        slice_sum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_q};
        carry_into_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1];
        ovf_calc       = carry_into_msb ^ slice_sum[DIGIT];
        acc_shift      = (acc_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef SEQ_ADDSUB_SAT_EN
        // Wrapped MSB 0 on overflow means the true result was negative, and vice versa.
        if (ovf_calc) begin
            final_res = acc_shift[WIDTH-1] ? {1'b0, {(WIDTH - 1){1'b1}}}
                                           : {1'b1, {(WIDTH - 1){1'b0}}};
        end else begin
            final_res = acc_shift;
        end
`else
        final_res = acc_shift;
`endif
    end

    // Datapath next-state: capture at accept, shift during RUN, latch outputs on the last slice.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = slice_sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last_slice) begin
                    result_d = final_res;
                    cout_d   = slice_sum[DIGIT];
                    ovf_d    = ovf_calc;
                    zero_d   = (final_res == '0);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Registered result and flags drive the bus.
    always_comb begin
        bus.result = result_q;
        bus.cout   = cout_q;
        bus.ovf    = ovf_q;
        bus.zero   = zero_q;
    end
endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on both sides. It processes one DIGIT-bit slice per clock, LSB first, with a registered carry between slices, which trades latency for area on wide operands. It replaces fixed 4-bit ripple subtract cells in datapaths that need wider operands, a run-time add/sub mode and status flags. It sits between an operand-issue stage and a result consumer.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥2 and a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; N = WIDTH/DIGIT cycles per operation.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  minuend / augend.
- b  input  WIDTH  subtrahend / addend.
- sub  input  1  1 = a−b, 0 = a+b; sampled at accept.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, mod 2^WIDTH (or saturated, see Configuration).
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0, after any saturation.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge: capture a, capture b (inverted if sub), capture sub; carry register ← sub; digit counter ← 0; go to RUN.
- RUN: each edge adds the low DIGIT bits of the a and b shift registers plus the carry, then:
  - shifts the sum slice into result from the MSB end;
  - shifts the operands right by DIGIT;
  - updates the carry and increments the counter.
- On the last slice (counter == N−1): compute cout, ovf and zero, then go to DONE. ovf needs the carry into bit WIDTH−1, taken from the slice-internal carry of the last digit.
- DONE: out_valid=1. result and flags hold stable until out_valid && out_ready, then go to IDLE.
- in_valid is ignored outside IDLE. a, b and sub may change freely after accept.
- DIGIT == WIDTH is legal: N=1 gives a single RUN cycle.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, carry=0, counter=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. No result is produced for the aborted operand.
- Parameter violations (WIDTH % DIGIT ≠ 0, DIGIT < 1) stop elaboration via a generate-time error.

## Timing
- Accept at edge k → out_valid rises after edge k+N. Latency is N+1 cycles counting the accept cycle.
- in_ready falls after the accept edge and stays low through RUN and DONE.
- Result handshake at edge m → in_ready high after edge m. Earliest next accept is edge m+1.
- Peak throughput is one operation per N+2 cycles.
- result and flags change only at the DONE entry edge and at reset. There are no combinational paths from inputs to outputs, except that in_ready decodes directly from state.

## Configuration
- SEQ_ADDSUB_SAT_EN defined: if ovf=1, result is saturated to the signed limit.
  - Overflow with result MSB 0 (negative true result) → 1 followed by zeros (most negative).
  - Overflow with result MSB 1 (positive true result) → 0 followed by ones (most positive).
  - ovf still reports 1. cout is unaffected. zero is computed on the saturated value.
- Undefined: result is the wrapped mod-2^WIDTH value. No saturation logic is present.

## Test plan
Defaults WIDTH=16, DIGIT=4, so N=4.
- sub=1, a=0x0005, b=0x0003 → result 0x0002, cout=1, ovf=0, zero=0; out_valid exactly 4 edges after accept.
- sub=1, a=0x0003, b=0x0005 → result 0xFFFE, cout=0, ovf=0; then sub=0, a=0xFFFF, b=0x0001 → 0x0000, cout=1, zero=1.
- Signed overflow, without / with SEQ_ADDSUB_SAT_EN (ovf=1 in all four cases):
  - sub=0, 0x7FFF+0x0001 → 0x8000 / 0x7FFF.
  - sub=1, 0x8000−0x0001 → 0x7FFF / 0x8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands → result and flags stable, in_ready=0, new operands not taken. Release out_ready → IDLE next edge, next op correct.
- Reset asserted after 2 RUN edges → out_valid=0, in_ready=1, all outputs 0. After release, 0x1234+0x1111 → 0x2345, cout=0.
- Re-parametrise WIDTH=8, DIGIT=8 and WIDTH=12, DIGIT=3 → random compare against a reference model over 1000 operations; latency N+1 each.
